// File: rtl/alu_op_sequencer_if.sv
// Command, response and ALU-side bundle for alu_op_sequencer.
// The sequencer uses the slave view; the surrounding environment uses the master view.
interface alu_op_sequencer_if #(
  parameter int unsigned WIDTH = 2,
  parameter int unsigned CNT_W = 8
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [WIDTH-1:0] cmd_a;
  logic [WIDTH-1:0] cmd_b;
  logic [1:0]       cmd_sel;

  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [1:0]       alu_sel;
  logic [WIDTH-1:0] alu_out;
  logic             alu_zero;
  logic             alu_carry;
  logic             alu_overflow;
  logic             alu_error;

  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] res_out;
  logic [3:0]       res_flags;
  logic             res_mismatch;
  logic [CNT_W-1:0] op_count;
  logic [CNT_W-1:0] mismatch_count;

  modport slave (
    input  cmd_valid, cmd_a, cmd_b, cmd_sel,
    output cmd_ready,
    output alu_a, alu_b, alu_sel,
    input  alu_out, alu_zero, alu_carry, alu_overflow, alu_error,
    output res_valid, res_out, res_flags, res_mismatch, op_count, mismatch_count,
    input  res_ready
  );

  modport master (
    output cmd_valid, cmd_a, cmd_b, cmd_sel,
    input  cmd_ready,
    input  alu_a, alu_b, alu_sel,
    output alu_out, alu_zero, alu_carry, alu_overflow, alu_error,
    input  res_valid, res_out, res_flags, res_mismatch, op_count, mismatch_count,
    output res_ready
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// Drives a small ALU with accepted commands, waits a fixed settle time, captures and
// self-checks the result, and returns it over valid/ready with saturating op/mismatch counters.
module alu_op_sequencer #(
  parameter int unsigned WIDTH         = 2,
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter int unsigned CNT_W         = 8
) (
  input logic               clk,
  input logic               rst,
  alu_op_sequencer_if.slave bus
);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES);

  state_t           r_state;
  logic [3:0]       r_settle;
  logic             r_cmd_ready;
  logic [WIDTH-1:0] r_alu_a;
  logic [WIDTH-1:0] r_alu_b;
  logic [1:0]       r_alu_sel;
  logic             r_res_valid;
  logic [WIDTH-1:0] r_res_out;
  logic [3:0]       r_res_flags;
  logic             r_res_mismatch;
  logic [CNT_W-1:0] r_op_count;
  logic [CNT_W-1:0] r_mismatch_count;

  logic [WIDTH-1:0] w_expected;
  logic             w_expected_zero;
  logic             w_mismatch;

  // Reference result from the latched operands; only out and zero are checked.
  always_comb begin
    w_expected = '0;
    case (r_alu_sel)
      2'b00:   w_expected = r_alu_a + r_alu_b;
      2'b01:   w_expected = r_alu_a - r_alu_b;
      2'b10:   w_expected = r_alu_a & r_alu_b;
      default: w_expected = r_alu_a | r_alu_b;
    endcase
    w_expected_zero = (w_expected == '0);
    w_mismatch      = (bus.alu_out != w_expected) || (bus.alu_zero != w_expected_zero);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state          <= IDLE;
      r_settle         <= '0;
      r_cmd_ready      <= 1'b1;
      r_alu_a          <= '0;
      r_alu_b          <= '0;
      r_alu_sel        <= '0;
      r_res_valid      <= 1'b0;
      r_res_out        <= '0;
      r_res_flags      <= '0;
      r_res_mismatch   <= 1'b0;
      r_op_count       <= '0;
      r_mismatch_count <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.cmd_valid) begin
            r_alu_a     <= bus.cmd_a;
            r_alu_b     <= bus.cmd_b;
            r_alu_sel   <= bus.cmd_sel;
            r_settle    <= SETTLE_LOAD;
            r_cmd_ready <= 1'b0;
            r_state     <= WAIT;
          end
        end
        WAIT: begin
          if (r_settle == 4'd1) begin
            r_res_out      <= bus.alu_out;
            r_res_flags    <= {bus.alu_error, bus.alu_overflow, bus.alu_carry, bus.alu_zero};
            r_res_mismatch <= w_mismatch;
            r_res_valid    <= 1'b1;
            r_state        <= RESP;
          end
          r_settle <= r_settle - 4'd1;
        end
        RESP: begin
          if (bus.res_ready) begin
            r_res_valid <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_state     <= IDLE;
            if (r_op_count != '1) r_op_count <= r_op_count + 1'b1;
            if (r_res_mismatch && (r_mismatch_count != '1))
              r_mismatch_count <= r_mismatch_count + 1'b1;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_cmd_ready <= 1'b1;
          r_res_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.cmd_ready      = r_cmd_ready;
  assign bus.alu_a          = r_alu_a;
  assign bus.alu_b          = r_alu_b;
  assign bus.alu_sel        = r_alu_sel;
  assign bus.res_valid      = r_res_valid;
  assign bus.res_out        = r_res_out;
  assign bus.res_flags      = r_res_flags;
  assign bus.res_mismatch   = r_res_mismatch;
  assign bus.op_count       = r_op_count;
  assign bus.mismatch_count = r_mismatch_count;
endmodule

// File: tb/tb_alu_op_sequencer.sv
// Two sequencer instances (default, and CNT_W=2/SETTLE_CYCLES=3) each driving a behavioural
// 2-bit ALU with an optional stuck-at-zero output fault.
module tb_alu_op_sequencer;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [1:0] t_a, t_b, t_sel;
  logic       t_valid, t_rready, dut_sel, fault;
  int         tests = 0;
  int         fails = 0;
  int         exp_ops [2];
  int         exp_mm  [2];

  alu_op_sequencer_if #(.WIDTH(2), .CNT_W(8)) bus0 ();
  alu_op_sequencer_if #(.WIDTH(2), .CNT_W(2)) bus1 ();

  alu_op_sequencer #(.WIDTH(2), .SETTLE_CYCLES(1), .CNT_W(8)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  alu_op_sequencer #(.WIDTH(2), .SETTLE_CYCLES(3), .CNT_W(2)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  function automatic logic [1:0] ideal(input logic [1:0] a, input logic [1:0] b, input logic [1:0] sel);
    int ia, ib;
    ia = int'(a);
    ib = int'(b);
    case (sel)
      2'd0:    return 2'((ia + ib) % 4);
      2'd1:    return 2'((ia - ib + 4) % 4);
      2'd2:    return 2'(ia & ib);
      default: return 2'(ia | ib);
    endcase
  endfunction

  function automatic logic [1:0] alu_out_m(input logic [1:0] a, input logic [1:0] b,
                                            input logic [1:0] sel, input logic f);
    return f ? 2'd0 : ideal(a, b, sel);
  endfunction

  // {error, overflow, carry, zero}; a faulty ALU also raises error.
  function automatic logic [3:0] alu_flags_m(input logic [1:0] a, input logic [1:0] b,
                                              input logic [1:0] sel, input logic f);
    int ia, ib, sa, sb, r;
    logic c, v, z;
    ia = int'(a);
    ib = int'(b);
    sa = (ia > 1) ? ia - 4 : ia;
    sb = (ib > 1) ? ib - 4 : ib;
    z = (alu_out_m(a, b, sel, f) == 2'd0);
    c = 1'b0;
    v = 1'b0;
    if (sel == 2'd0) begin
      c = (ia + ib) > 3;
      r = sa + sb;
      v = (r < -2) || (r > 1);
    end else if (sel == 2'd1) begin
      c = ia < ib;
      r = sa - sb;
      v = (r < -2) || (r > 1);
    end
    return {f, v, c, z};
  endfunction

  assign bus0.cmd_a = t_a;
  assign bus0.cmd_b = t_b;
  assign bus0.cmd_sel = t_sel;
  assign bus0.cmd_valid = t_valid & ~dut_sel;
  assign bus0.res_ready = t_rready & ~dut_sel;
  assign bus0.alu_out = alu_out_m(bus0.alu_a, bus0.alu_b, bus0.alu_sel, fault);
  assign {bus0.alu_error, bus0.alu_overflow, bus0.alu_carry, bus0.alu_zero} =
    alu_flags_m(bus0.alu_a, bus0.alu_b, bus0.alu_sel, fault);

  assign bus1.cmd_a = t_a;
  assign bus1.cmd_b = t_b;
  assign bus1.cmd_sel = t_sel;
  assign bus1.cmd_valid = t_valid & dut_sel;
  assign bus1.res_ready = t_rready & dut_sel;
  assign bus1.alu_out = alu_out_m(bus1.alu_a, bus1.alu_b, bus1.alu_sel, fault);
  assign {bus1.alu_error, bus1.alu_overflow, bus1.alu_carry, bus1.alu_zero} =
    alu_flags_m(bus1.alu_a, bus1.alu_b, bus1.alu_sel, fault);

  logic       o_cmd_ready, o_res_valid, o_res_mismatch;
  logic [1:0] o_res_out, o_alu_a, o_alu_b, o_alu_sel;
  logic [3:0] o_res_flags;
  logic [7:0] o_ops, o_mm;

  always_comb begin
    if (dut_sel) begin
      o_cmd_ready = bus1.cmd_ready;   o_res_valid = bus1.res_valid;
      o_res_mismatch = bus1.res_mismatch;
      o_res_out = bus1.res_out;       o_res_flags = bus1.res_flags;
      o_alu_a = bus1.alu_a;           o_alu_b = bus1.alu_b;   o_alu_sel = bus1.alu_sel;
      o_ops = {6'b0, bus1.op_count};  o_mm = {6'b0, bus1.mismatch_count};
    end else begin
      o_cmd_ready = bus0.cmd_ready;   o_res_valid = bus0.res_valid;
      o_res_mismatch = bus0.res_mismatch;
      o_res_out = bus0.res_out;       o_res_flags = bus0.res_flags;
      o_alu_a = bus0.alu_a;           o_alu_b = bus0.alu_b;   o_alu_sel = bus0.alu_sel;
      o_ops = bus0.op_count;          o_mm = bus0.mismatch_count;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, dut_sel, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_op(input logic [1:0] a, input logic [1:0] b, input logic [1:0] sel,
                       input logic f, input int stall);
    int n, d, settle, sat;
    logic [1:0] eo, ei;
    logic [3:0] ef;
    logic em;
    d = dut_sel ? 1 : 0;
    settle = dut_sel ? 3 : 1;
    sat = dut_sel ? 3 : 255;
    ei = ideal(a, b, sel);
    eo = f ? 2'd0 : ei;
    ef = alu_flags_m(a, b, sel, f);
    em = (eo != ei) || ((eo == 2'd0) != (ei == 2'd0));

    n = 0;
    while (!o_cmd_ready && n < 20) begin tick(); n++; end
    chk("cmd_ready_idle", 32'(o_cmd_ready), 32'd1);
    t_a = a; t_b = b; t_sel = sel; fault = f; t_valid = 1'b1; t_rready = 1'b0;
    tick();
    t_valid = 1'b0;
    chk("cmd_ready_wait", 32'(o_cmd_ready), 32'd0);
    chk("alu_drive", 32'({o_alu_a, o_alu_b, o_alu_sel}), 32'({a, b, sel}));

    n = 0;
    while (!o_res_valid && n < 20) begin
      t_a = 2'($urandom);
      tick();
      n++;
    end
    chk("latency", 32'(n), 32'(settle));
    chk("res_out", 32'(o_res_out), 32'(eo));
    chk("res_flags", 32'(o_res_flags), 32'(ef));
    chk("res_mismatch", 32'(o_res_mismatch), 32'(em));
    chk("cmd_ready_resp", 32'(o_cmd_ready), 32'd0);

    for (int i = 0; i < stall; i++) begin
      t_valid = 1'($urandom_range(0, 1));
      t_a = 2'($urandom);
      tick();
      chk("hold_valid", 32'(o_res_valid), 32'd1);
      chk("hold_res", 32'({o_res_out, o_res_flags, o_res_mismatch}), 32'({eo, ef, em}));
      chk("hold_cmd_ready", 32'(o_cmd_ready), 32'd0);
      chk("hold_alu_a", 32'(o_alu_a), 32'(a));
    end

    // A command offered on the completing edge must not be taken.
    t_valid = (stall > 0);
    t_a = ~a;
    t_rready = 1'b1;
    tick();
    t_valid = 1'b0;
    t_rready = 1'b0;
    exp_ops[d] = (exp_ops[d] < sat) ? exp_ops[d] + 1 : sat;
    if (em) exp_mm[d] = (exp_mm[d] < sat) ? exp_mm[d] + 1 : sat;
    chk("done_valid", 32'(o_res_valid), 32'd0);
    chk("done_cmd_ready", 32'(o_cmd_ready), 32'd1);
    chk("done_alu_a", 32'(o_alu_a), 32'(a));
    chk("done_res_out", 32'(o_res_out), 32'(eo));
    chk("op_count", 32'(o_ops), 32'(exp_ops[d]));
    chk("mismatch_count", 32'(o_mm), 32'(exp_mm[d]));
  endtask

  task automatic chk_reset_state();
    for (int s = 0; s < 2; s++) begin
      dut_sel = 1'(s);
      #1;
      chk("rst_res_valid", 32'(o_res_valid), 32'd0);
      chk("rst_cmd_ready", 32'(o_cmd_ready), 32'd1);
      chk("rst_alu", 32'({o_alu_a, o_alu_b, o_alu_sel}), 32'd0);
      chk("rst_res", 32'({o_res_out, o_res_flags, o_res_mismatch}), 32'd0);
      chk("rst_counts", 32'({o_ops, o_mm}), 32'd0);
    end
    dut_sel = 1'b0;
    #1;
    exp_ops[0] = 0; exp_ops[1] = 0; exp_mm[0] = 0; exp_mm[1] = 0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; t_a = '0; t_b = '0; t_sel = '0; t_valid = 1'b0; t_rready = 1'b0;
    dut_sel = 1'b0; fault = 1'b0;
    exp_ops[0] = 0; exp_ops[1] = 0; exp_mm[0] = 0; exp_mm[1] = 0;
    tick(); tick();
    rst = 1'b0;
    chk_reset_state();

    // Directed operations on the default instance.
    do_op(2'b01, 2'b01, 2'b00, 1'b0, 0);
    do_op(2'b11, 2'b01, 2'b00, 1'b0, 0);
    do_op(2'b11, 2'b01, 2'b01, 1'b0, 0);
    do_op(2'b11, 2'b01, 2'b10, 1'b0, 0);
    do_op(2'b10, 2'b01, 2'b11, 1'b0, 0);
    do_op(2'b10, 2'b11, 2'b01, 1'b0, 6);
    do_op(2'b11, 2'b01, 2'b10, 1'b1, 0);
    do_op(2'b01, 2'b10, 2'b11, 1'b0, 0);

    // Randomized operations, stalls and faults.
    for (int i = 0; i < 40; i++)
      do_op(2'($urandom), 2'($urandom), 2'($urandom), ($urandom_range(0, 3) == 0),
            int'($urandom_range(0, 3)));

    // Reset while waiting for the ALU to settle.
    t_a = 2'b10; t_b = 2'b01; t_sel = 2'b00; t_valid = 1'b1;
    tick();
    t_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_reset_state();
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("no_late_resp_wait", 32'(o_res_valid), 32'd0);
    end

    // Reset while a response is pending.
    do_op(2'b01, 2'b01, 2'b01, 1'b0, 0);
    t_a = 2'b11; t_b = 2'b11; t_sel = 2'b11; t_valid = 1'b1;
    tick();
    t_valid = 1'b0;
    tick();
    chk("resp_before_rst", 32'(o_res_valid), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_reset_state();
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("no_late_resp_resp", 32'(o_res_valid), 32'd0);
    end

    // Narrow-counter, long-settle instance: saturation at 3.
    dut_sel = 1'b1;
    #1;
    do_op(2'b01, 2'b01, 2'b00, 1'b0, 0);
    do_op(2'b11, 2'b01, 2'b10, 1'b1, 1);
    do_op(2'b10, 2'b01, 2'b11, 1'b0, 0);
    do_op(2'b11, 2'b10, 2'b01, 1'b0, 2);
    do_op(2'b00, 2'b00, 2'b00, 1'b0, 0);
    chk("op_count_saturated", 32'(o_ops), 32'd3);
    for (int i = 0; i < 8; i++)
      do_op(2'($urandom), 2'($urandom), 2'($urandom), ($urandom_range(0, 1) == 0),
            int'($urandom_range(0, 2)));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
Initiator-side driver for the 2-bit ALU (ports a, b, sel in; out, zero, carry, overflow, error out). It accepts operation commands over a valid/ready interface, registers and drives the ALU inputs, and waits a fixed settle time. It then captures the ALU result and flags, checks out/zero against an internal reference model, and presents a response over valid/ready. It also keeps saturating completed-operation and mismatch counters for on-chip self-test of the ALU.

Parameters:
WIDTH, 2, operand/result width; must match the ALU.
SETTLE_CYCLES, 1, clock edges between driving ALU inputs and capturing outputs; legal range 1..15.
CNT_W, 8, width of op_count and mismatch_count.

Ports:
clk  in  1  single clock, rising edge
rst  in  1  synchronous, active-high reset
cmd_valid  in  1  command present
cmd_ready  out  1  block can accept a command
cmd_a  in  WIDTH  operand A
cmd_b  in  WIDTH  operand B
cmd_sel  in  2  opcode: 00 ADD, 01 SUB, 10 AND, 11 OR
alu_a  out  WIDTH  to ALU a
alu_b  out  WIDTH  to ALU b
alu_sel  out  2  to ALU sel
alu_out  in  WIDTH  from ALU out
alu_zero, alu_carry, alu_overflow, alu_error  in  1 each  ALU flags
res_valid  out  1  response present
res_ready  in  1  consumer accepts response
res_out  out  WIDTH  captured alu_out
res_flags  out  4  captured {error, overflow, carry, zero}
res_mismatch  out  1  captured out/zero disagreed with reference model
op_count  out  CNT_W  completed responses, saturating
mismatch_count  out  CNT_W  completed responses with res_mismatch=1, saturating

Behaviour:
- Reset (rst high at a clk edge): state IDLE. alu_a, alu_b, alu_sel, res_out, res_flags, res_mismatch, op_count, mismatch_count = 0. res_valid = 0. cmd_ready = 1 after reset. Any in-flight command is dropped. rst has priority over all other events.
- FSM states IDLE, WAIT, RESP. cmd_ready = (state==IDLE), registered/decoded from state only; it has no combinational path from res_ready.
- IDLE: on cmd_valid&cmd_ready at edge E0, latch cmd_a/b/sel into alu_a/b/sel, load settle counter = SETTLE_CYCLES, go to WAIT. alu_* hold these values until the next accepted command.
- WAIT: the counter decrements each edge. At the edge where the counter equals 1, capture alu_out into res_out and the flags into res_flags, and compute res_mismatch. Set res_valid=1 and go to RESP. res_valid therefore rises SETTLE_CYCLES edges after E0.
- Reference model, computed on latched operands modulo 2^WIDTH: ADD a+b, SUB a-b, AND a&b, OR a|b. Expected zero = (expected out == 0). res_mismatch = (alu_out != expected) | (alu_zero != expected zero). carry/overflow/error are captured but not checked.
- RESP: res_valid and res_* are held stable while res_ready=0. On res_valid&res_ready at an edge:
  - res_valid goes to 0 and state to IDLE.
  - op_count increments unless all-ones.
  - mismatch_count increments if res_mismatch is set and it is not all-ones.
  - res_* keep their last values.
- Throughput: at most one op per SETTLE_CYCLES+2 cycles. A command cannot be accepted in the same cycle a response completes.
- Counters saturate at 2^CNT_W-1; they never wrap.
- cmd_* changes outside an accepting edge have no effect.

Test Plan:
- Reset, then sel=00 a=01 b=01 -> res_valid after 1 edge (SETTLE=1); res_out=10, zero=0, carry=0, res_mismatch=0; op_count=1 after handshake.
- ADD 11+01, then SUB 11-01, AND 11&01, OR 10|01 back-to-back with res_ready=1 -> res_out 00 (zero=1, carry=1), 10, 01, 11; no mismatches; op_count=5 total; cmd_ready low in WAIT/RESP.
- Hold res_ready=0 for 6 cycles with a response pending and toggle cmd_valid/cmd_a -> res_* stable, cmd_ready=0, no new command accepted; release -> single handshake, op_count+1.
- Faulty ALU model forcing out=00 on AND 11&01 -> res_mismatch=1, mismatch_count=1; subsequent correct op -> res_mismatch=0, count unchanged.
- rst asserted for one edge while in WAIT, then while in RESP -> res_valid=0, alu_*=0, counters=0, cmd_ready=1 next cycle; no late response appears.
- CNT_W=2, SETTLE_CYCLES=3 -> res_valid 3 edges after accept; after 5 completed ops op_count=11 (saturated, no wrap).
